// File: rtl/vdp_vram_if.sv
// VRAM arbiter bus: BG/SPR read ports, CPU data port and the VRAM macro pins.
// slave = arbiter side, master = requesters / memory side.
interface vdp_vram_if;
  logic        bg_req;
  logic [13:0] bg_addr;
  logic        bg_gnt;
  logic        bg_valid;
  logic [7:0]  bg_data;

  logic        spr_req;
  logic [13:0] spr_addr;
  logic        spr_gnt;
  logic        spr_valid;
  logic [7:0]  spr_data;

  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  modport slave (
    input  bg_req, bg_addr, spr_req, spr_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vram_rdata,
    output bg_gnt, bg_valid, bg_data,
    output spr_gnt, spr_valid, spr_data,
    output cpu_ack, cpu_rdata,
    output vram_addr, vram_we, vram_wdata
  );

  modport master (
    output bg_req, bg_addr, spr_req, spr_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vram_rdata,
    input  bg_gnt, bg_valid, bg_data,
    input  spr_gnt, spr_valid, spr_data,
    input  cpu_ack, cpu_rdata,
    input  vram_addr, vram_we, vram_wdata
  );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: BG owns active display, SPR owns hblank, CPU fills idle cycles.
// Optional `VDP_VRAM_CPU_SLOT_EN adds a periodic guaranteed CPU slot.
module vdp_vram_arbiter #(
  parameter int HBLANK_START    = 256,
  parameter int CPU_SLOT_PERIOD = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  pixel_x_i,
  vdp_vram_if.slave   bus
);

  typedef enum logic [1:0] {TAG_NONE, TAG_BG, TAG_SPR, TAG_CPU} tag_e;
  typedef enum logic [2:0] {CPU_IDLE, CPU_PEND, CPU_RD1, CPU_RD2, CPU_ACK} cpu_st_e;

  typedef struct packed {
    logic        req;
    logic [13:0] addr;
  } rd_req_t;

  localparam logic [9:0] HBL = 10'(HBLANK_START);

  rd_req_t     bg_r, spr_r;
  logic        blank;
  logic        cpu_elig;
  logic        slot_hit;
  tag_e        win;

  tag_e        tag_d1_q, tag_d1_d, tag_d2_q;
  cpu_st_e     cpu_st_q, cpu_st_d;
  logic [13:0] vram_addr_q, vram_addr_d;
  logic        vram_we_q, vram_we_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;

  assign bg_r     = '{req: bus.bg_req,  addr: bus.bg_addr};
  assign spr_r    = '{req: bus.spr_req, addr: bus.spr_addr};
  assign blank    = (pixel_x_i >= HBL);
  assign cpu_elig = (cpu_st_q == CPU_PEND);

`ifdef VDP_VRAM_CPU_SLOT_EN
  localparam int SW = (CPU_SLOT_PERIOD > 1) ? $clog2(CPU_SLOT_PERIOD) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(CPU_SLOT_PERIOD - 1);

  logic [SW-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q + 1'b1;
    if (slot_q == SLOT_LAST) slot_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_hit = (slot_q == '0) && cpu_elig;
`else
  logic unused_slot_period;
  assign unused_slot_period = ^CPU_SLOT_PERIOD;
  assign slot_hit = 1'b0;
`endif

  // Grants are suppressed during reset so a requester never advances on a dropped access.
  always_comb begin
    win = TAG_NONE;
    if (!rst_i) begin
      if (slot_hit)          win = TAG_CPU;
      else if (!blank) begin
        if (bg_r.req)        win = TAG_BG;
        else if (cpu_elig)   win = TAG_CPU;
        else if (spr_r.req)  win = TAG_SPR;
      end else begin
        if (spr_r.req)       win = TAG_SPR;
        else if (cpu_elig)   win = TAG_CPU;
        else if (bg_r.req)   win = TAG_BG;
      end
    end
  end

  always_comb begin
    vram_addr_d  = vram_addr_q;
    vram_we_d    = 1'b0;
    vram_wdata_d = vram_wdata_q;
    tag_d1_d     = win;
    case (win)
      TAG_BG:  vram_addr_d = bg_r.addr;
      TAG_SPR: vram_addr_d = spr_r.addr;
      TAG_CPU: begin
        vram_addr_d = bus.cpu_addr;
        vram_we_d   = bus.cpu_we;
      end
      default: ;
    endcase
    if (win != TAG_NONE) vram_wdata_d = bus.cpu_wdata;
  end

  // CPU reads land in cpu_rdata at the end of RD2, the cycle vram_rdata carries them.
  always_comb begin
    cpu_st_d    = cpu_st_q;
    cpu_rdata_d = cpu_rdata_q;
    case (cpu_st_q)
      CPU_IDLE: if (bus.cpu_req) cpu_st_d = CPU_PEND;
      CPU_PEND: if (win == TAG_CPU) cpu_st_d = bus.cpu_we ? CPU_ACK : CPU_RD1;
      CPU_RD1:  cpu_st_d = CPU_RD2;
      CPU_RD2: begin
        cpu_rdata_d = bus.vram_rdata;
        cpu_st_d    = CPU_ACK;
      end
      CPU_ACK:  cpu_st_d = CPU_IDLE;
      default:  cpu_st_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpu_st_q     <= CPU_IDLE;
      tag_d1_q     <= TAG_NONE;
      tag_d2_q     <= TAG_NONE;
      vram_addr_q  <= '0;
      vram_we_q    <= 1'b0;
      vram_wdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      cpu_st_q     <= cpu_st_d;
      tag_d1_q     <= tag_d1_d;
      tag_d2_q     <= tag_d1_q;
      vram_addr_q  <= vram_addr_d;
      vram_we_q    <= vram_we_d;
      vram_wdata_q <= vram_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign bus.bg_gnt     = (win == TAG_BG);
  assign bus.spr_gnt    = (win == TAG_SPR);
  assign bus.bg_valid   = (tag_d2_q == TAG_BG);
  assign bus.spr_valid  = (tag_d2_q == TAG_SPR);
  assign bus.bg_data    = bus.vram_rdata;
  assign bus.spr_data   = bus.vram_rdata;
  assign bus.cpu_ack    = (cpu_st_q == CPU_ACK);
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vram_addr  = vram_addr_q;
  assign bus.vram_we    = vram_we_q;
  assign bus.vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: directed scenarios plus random traffic against a
// latency/priority reference model with its own memory image.
module tb_vdp_vram_arbiter;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixel_x;

  vdp_vram_if bus();

  vdp_vram_arbiter #(.HBLANK_START(256), .CPU_SLOT_PERIOD(P)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .pixel_x_i (pixel_x),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
  endfunction

  // VRAM macro: synchronous, 1-cycle read latency
  logic [7:0] ram [16384];
  bit         wr_seen [16384];
  always @(posedge clk) begin
    if (bus.vram_we) begin
      ram[bus.vram_addr]     <= bus.vram_wdata;
      wr_seen[bus.vram_addr] <= 1'b1;
    end
    bus.vram_rdata <= wr_seen[bus.vram_addr] ? ram[bus.vram_addr] : init_val(bus.vram_addr);
  end

  // ---------------- reference model ----------------
  logic [7:0] mm [int];
  int         vectors = 0, miscompares = 0;
  int         rcyc = 0;
  bit         e_bgv[4], e_sprv[4], e_ack[4], e_rd[4];
  logic [7:0] e_dat[4], e_rdat[4];
  logic [13:0] m_vaddr;
  logic [7:0]  m_vwdata, m_rdata;
  bit          m_vwe;
  bit          c_act, c_gnt;
  int          c_start;

  function automatic logic [7:0] mread(input logic [13:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, rcyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      e_bgv[k] = 0; e_sprv[k] = 0; e_ack[k] = 0; e_rd[k] = 0;
    end
    m_vaddr = '0; m_vwdata = '0; m_rdata = '0; m_vwe = 0;
    c_act = 0; c_gnt = 0; rcyc = 0;
  endtask

  // One clock: check at negedge, advance model, return #1 after next posedge.
  task automatic tick();
    int  w, i;
    bit  slot, ce, blank, ack_now;
    @(negedge clk);
`ifdef VDP_VRAM_CPU_SLOT_EN
    slot = ((rcyc % P) == 0);
`else
    slot = 0;
`endif
    ce    = c_act && !c_gnt && (rcyc >= c_start + 1);
    blank = (pixel_x >= 10'd256);
    w = 0;
    if (ce && slot)  w = 3;
    else if (!blank) w = bus.bg_req ? 1 : ce ? 3 : bus.spr_req ? 2 : 0;
    else             w = bus.spr_req ? 2 : ce ? 3 : bus.bg_req ? 1 : 0;

    i = rcyc % 4;
    chk("bg_gnt", bus.bg_gnt, w == 1);
    chk("spr_gnt", bus.spr_gnt, w == 2);
    chk("bg_valid", bus.bg_valid, e_bgv[i]);
    chk("spr_valid", bus.spr_valid, e_sprv[i]);
    if (e_bgv[i])  chk("bg_data", bus.bg_data, e_dat[i]);
    if (e_sprv[i]) chk("spr_data", bus.spr_data, e_dat[i]);
    chk("cpu_ack", bus.cpu_ack, e_ack[i]);
    if (e_ack[i] && e_rd[i]) m_rdata = e_rdat[i];
    chk("cpu_rdata", bus.cpu_rdata, m_rdata);
    chk("vram_we", bus.vram_we, m_vwe);
    chk("vram_addr", bus.vram_addr, m_vaddr);
    chk("vram_wdata", bus.vram_wdata, m_vwdata);
    ack_now = e_ack[i];
    e_bgv[i] = 0; e_sprv[i] = 0; e_ack[i] = 0; e_rd[i] = 0;

    m_vwe = 0;
    if (w != 0) m_vwdata = bus.cpu_wdata;
    case (w)
      1: begin
        m_vaddr = bus.bg_addr;
        e_bgv[(rcyc + 2) % 4] = 1; e_dat[(rcyc + 2) % 4] = mread(bus.bg_addr);
      end
      2: begin
        m_vaddr = bus.spr_addr;
        e_sprv[(rcyc + 2) % 4] = 1; e_dat[(rcyc + 2) % 4] = mread(bus.spr_addr);
      end
      3: begin
        m_vaddr = bus.cpu_addr;
        c_gnt = 1;
        if (bus.cpu_we) begin
          mm[int'(bus.cpu_addr)] = bus.cpu_wdata;
          m_vwe = 1;
          e_ack[(rcyc + 1) % 4] = 1;
        end else begin
          e_ack[(rcyc + 3) % 4] = 1; e_rd[(rcyc + 3) % 4] = 1;
          e_rdat[(rcyc + 3) % 4] = mread(bus.cpu_addr);
        end
      end
      default: ;
    endcase
    rcyc++;
    @(posedge clk); #1;
    if (w == 1) bus.bg_req = 0;
    if (w == 2) bus.spr_req = 0;
    if (ack_now) begin bus.cpu_req = 0; c_act = 0; end
  endtask

  task automatic cpu_start(input bit we, input logic [13:0] a, input logic [7:0] d);
    bus.cpu_req = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    c_act = 1; c_gnt = 0; c_start = rcyc;
  endtask

  task automatic cpu_wait(input int budget);
    for (int k = 0; k < budget && c_act; k++) tick();
    chk("cpu_done_in_budget", c_act, 0);
  endtask

  task automatic do_reset();
    rst = 1; bus.bg_req = 0; bus.spr_req = 0; bus.cpu_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_vram_addr", bus.vram_addr, 0);
    chk("rst_vram_we", bus.vram_we, 0);
    chk("rst_vram_wdata", bus.vram_wdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_bg_valid", bus.bg_valid, 0);
    chk("rst_spr_valid", bus.spr_valid, 0);
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    model_clear();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; pixel_x = '0;
    bus.bg_req = 0; bus.bg_addr = '0; bus.spr_req = 0; bus.spr_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    do_reset();

    // BG single read in active display
    pixel_x = 10'd10; bus.bg_req = 1; bus.bg_addr = 14'h1234;
    repeat (4) tick();

    // BG vs SPR: active then blank
    pixel_x = 10'd100; bus.bg_req = 1; bus.bg_addr = 14'h0100;
    bus.spr_req = 1; bus.spr_addr = 14'h0200;
    repeat (2) tick();
    pixel_x = 10'd256; bus.bg_req = 1; bus.bg_addr = 14'h0300;
    bus.spr_req = 1; bus.spr_addr = 14'h0400;
    repeat (4) tick();

    // CPU write then read-back at top address
    pixel_x = 10'd100;
    cpu_start(1'b1, 14'h3FFF, 8'hA5);
    cpu_wait(10);
    cpu_start(1'b0, 14'h3FFF, 8'h00);
    cpu_wait(10);
    repeat (2) tick();

    // CPU read under continuous BG pressure in active display
    pixel_x = 10'd20;
    cpu_start(1'b0, 14'h0042, 8'h00);
    for (int k = 0; k < 20; k++) begin
      bus.bg_req = 1; bus.bg_addr = 14'($urandom);
      tick();
    end
    bus.bg_req = 0;
    cpu_wait(10);
    repeat (3) tick();

    // Reset one cycle after a BG grant drops the read
    pixel_x = 10'd30; bus.bg_req = 1; bus.bg_addr = 14'h0555;
    tick();
    do_reset();
    cpu_start(1'b1, 14'h0010, 8'h3C);
    cpu_wait(10);

    // Six back-to-back SPR reads in blank
    for (int k = 0; k < 6; k++) begin
      pixel_x = 10'(260 + k); bus.spr_req = 1; bus.spr_addr = 14'($urandom_range(0, 63));
      tick();
    end
    repeat (3) tick();

    // Random traffic sweeping the scanline
    pixel_x = 10'd0;
    for (int n = 0; n < 3000; n++) begin
      pixel_x = (pixel_x >= 10'd341) ? 10'd0 : pixel_x + 10'd1;
      if ($urandom_range(0, 40) == 0) pixel_x = 10'($urandom_range(250, 262));
      if (!bus.bg_req && $urandom_range(0, 2) == 0) begin
        bus.bg_req = 1; bus.bg_addr = 14'($urandom_range(0, 63));
      end
      if (!bus.spr_req && $urandom_range(0, 2) == 0) begin
        bus.spr_req = 1; bus.spr_addr = 14'($urandom_range(0, 63));
      end
      if (!c_act && $urandom_range(0, 5) == 0)
        cpu_start(1'($urandom), 14'($urandom_range(0, 63)), 8'($urandom));
      else if (c_act && c_gnt) begin
        bus.cpu_we = 1'($urandom); bus.cpu_addr = 14'($urandom); bus.cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 700) == 0) do_reset();
      else tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vdp_vram_arbiter.md
Name: vdp_vram_arbiter

Overview:
- Shares the single-port VDP VRAM between three requesters: background fetcher (BG), sprite fetcher (SPR), and the CPU data port.
- Priority is scheduled from pixel_x: BG owns active display and SPR owns horizontal blank. The CPU takes any cycle the scheduled owner leaves idle.
- Sits between vdp_sprites, the background engine, the CPU I/O decode and the VRAM macro, which is synchronous with 1-cycle read latency.

Parameters:
- HBLANK_START, 256, first pixel_x of the blank phase; pixel_x below this is the ACTIVE phase.
- CPU_SLOT_PERIOD, 8, period in cycles of the guaranteed CPU slot; used only with CPU_SLOT_EN.

Ports:
- clk  in  1  VDP pixel clock
- rst  in  1  synchronous, active-high reset
- pixel_x  in  10  current horizontal position
- bg_req  in  1  BG read request; held with bg_addr until granted
- bg_addr  in  14  BG read address
- bg_gnt  out  1  combinational grant; BG may advance next cycle
- bg_valid  out  1  bg_data holds BG read data
- bg_data  out  8  equals vram_rdata
- spr_req  in  1  SPR read request; same rules as BG
- spr_addr  in  14  SPR read address
- spr_gnt  out  1  combinational grant
- spr_valid  out  1  spr_data holds SPR read data
- spr_data  out  8  equals vram_rdata
- cpu_req  in  1  level request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  14  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  registered CPU read data
- vram_addr  out  14  registered VRAM address
- vram_we  out  1  registered VRAM write enable
- vram_wdata  out  8  registered VRAM write data
- vram_rdata  in  8  VRAM read data, valid the cycle after address

Behaviour:
- Reset values:
  - vram_addr=0, vram_we=0, vram_wdata=0, cpu_rdata=0.
  - bg_valid, spr_valid and cpu_ack all 0.
  - Tag pipeline set to NONE, CPU FSM set to IDLE, slot counter set to 0.
- Reset mid-operation: in-flight reads are discarded; no valid or ack is issued for them.
- Arbitration is combinational in cycle C and picks at most one requester:
  - ACTIVE phase: BG > CPU > SPR.
  - BLANK phase (pixel_x >= HBLANK_START): SPR > CPU > BG.
  - The phase comes from the current pixel_x, so priority flips in the same cycle pixel_x reaches HBLANK_START and again at 0.
- A CPU request is eligible only in CPU FSM state PEND.
- On a grant in cycle C, at the end of C:
  - vram_addr is loaded from the winner's address.
  - vram_we = winner is CPU and cpu_we=1.
  - vram_wdata = cpu_wdata.
  - tag_d1 is loaded with the winner ID.
- With no grant: vram_we=0, vram_addr holds its value, tag_d1=NONE.
- tag_d1 shifts into tag_d2.
- Read return timing:
  - bg_valid = (tag_d2==BG), and spr_valid likewise, both in cycle C+2.
  - vram_we is high for exactly one cycle per write.
  - BG and SPR are read-only.
- Sustained throughput is one access per cycle; back-to-back grants to the same requester are legal.
- CPU FSM:
  - IDLE: cpu_req=1 -> PEND.
  - PEND: on grant, a write goes to ACK and a read goes to RD1.
  - RD1 -> RD2.
  - RD2: cpu_rdata <= vram_rdata at the end of RD2 -> ACK.
  - ACK: cpu_ack=1 for one cycle -> IDLE.
- CPU latency:
  - Write: cpu_ack in C+1.
  - Read: cpu_ack in C+3, with cpu_rdata stable from C+3 until the next read completes.
- The CPU drops cpu_req in the cycle after cpu_ack. If cpu_req is still high in IDLE, a new transaction starts.
- cpu_addr, cpu_we and cpu_wdata are sampled only at grant; later changes do not affect the transaction in flight.
- Starvation: the CPU waits indefinitely while the scheduled owner requests every cycle (base build).

Optional Feature:
- Macro: VDP_VRAM_CPU_SLOT_EN.
- When defined:
  - A free-running counter cycles 0..CPU_SLOT_PERIOD-1.
  - When the counter is 0 and the CPU FSM is in PEND, the CPU has top priority in both phases, and BG/SPR get gnt=0 that cycle.
  - Worst-case CPU wait is CPU_SLOT_PERIOD cycles.
- When undefined: the counter is absent and the base priorities apply.

Test Plan:
- BG read 0x1234 at pixel_x=10, no other requests -> bg_gnt in C; vram_addr=0x1234 in C+1; bg_valid=1 in C+2 with bg_data=RAM[0x1234].
- BG and SPR both request at pixel_x=100 -> BG granted first; at pixel_x=256 with both requesting -> SPR granted.
- CPU write 0x3FFF<-0xA5 during an idle cycle -> vram_we=1 for one cycle in C+1 with vram_addr=0x3FFF, vram_wdata=0xA5; cpu_ack in C+1. A following CPU read of 0x3FFF -> cpu_ack in C+3 with cpu_rdata=0xA5.
- CPU read while BG requests continuously for 20 cycles in ACTIVE -> no cpu_ack (base build). With VDP_VRAM_CPU_SLOT_EN -> granted within 8 cycles; BG bg_gnt=0 in that slot cycle.
- rst asserted the cycle after a BG grant -> no bg_valid; all outputs at reset values next cycle; CPU FSM IDLE.
- Back-to-back SPR requests on 6 consecutive blank cycles -> 6 grants and 6 spr_valid pulses in order, each delayed 2 cycles from its grant.
